// File: rtl/tawas_ld_wb_sched.sv
// Load writeback scheduler: per-slice pending scoreboard plus return FIFO,
// draining into the regfile load port only in the committing bank's cycle.
module tawas_ld_wb_sched #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SLICE,
  input  logic        RD_REQ,
  input  logic [2:0]  RD_REQ_SEL,
  output logic        RD_REQ_RDY,
  input  logic        RD_RTN_VLD,
  input  logic        RD_RTN_SLICE,
  input  logic [2:0]  RD_RTN_SEL,
  input  logic [31:0] RD_RTN_DATA,
  output logic        LS_LOAD_VLD,
  output logic [2:0]  LS_LOAD_SEL,
  output logic [31:0] LS_LOAD,
  output logic [7:0]  PEND_0,
  output logic [7:0]  PEND_1,
  output logic        ERR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [2:0]    sel_q  [2][DEPTH];
  logic [2:0]    sel_d  [2][DEPTH];
  logic [31:0]   data_q [2][DEPTH];
  logic [31:0]   data_d [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] wptr_d [2];
  logic [PW-1:0] rptr_q [2];
  logic [PW-1:0] rptr_d [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic [7:0]    pend_q [2];
  logic [7:0]    pend_d [2];
  logic          err_q, err_d;

  logic [1:0]    empty_c, full_c;
  logic          cbank_c;
  logic [2:0]    head_sel_c;
  logic [31:0]   head_data_c;
  logic          issue_c, pop_c, enq_c;

  function automatic logic [AW-1:0] ptr_idx(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    else            return AW'(p);
  endfunction

  // FIFO status: pointers differ only in the wrap bit when full
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      empty_c[s] = (wptr_q[s] == rptr_q[s]);
      full_c[s]  = ((wptr_q[s] ^ rptr_q[s]) == PW'(DEPTH));
    end
  end

  // Committing bank head drives the regfile port; no path from the return bus
  always_comb begin
    cbank_c     = ~SLICE;
    head_sel_c  = sel_q[cbank_c][ptr_idx(rptr_q[cbank_c])];
    head_data_c = data_q[cbank_c][ptr_idx(rptr_q[cbank_c])];
    LS_LOAD_VLD = ~empty_c[cbank_c];
    LS_LOAD_SEL = LS_LOAD_VLD ? head_sel_c  : 3'd0;
    LS_LOAD     = LS_LOAD_VLD ? head_data_c : 32'd0;
    RD_REQ_RDY  = (cnt_q[SLICE] < CW'(DEPTH)) && !pend_q[SLICE][RD_REQ_SEL];
    PEND_0      = pend_q[0];
    PEND_1      = pend_q[1];
    ERR         = err_q;
  end

  always_comb begin
    sel_d   = sel_q;
    data_d  = data_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    issue_c = RD_REQ && RD_REQ_RDY;
    pop_c   = LS_LOAD_VLD;
    // Full is judged before this edge's pop
    enq_c   = RD_RTN_VLD && !full_c[RD_RTN_SLICE] && pend_q[RD_RTN_SLICE][RD_RTN_SEL];
    err_d   = err_q || (RD_RTN_VLD && !enq_c);

    if (enq_c) begin
      sel_d[RD_RTN_SLICE][ptr_idx(wptr_q[RD_RTN_SLICE])]  = RD_RTN_SEL;
      data_d[RD_RTN_SLICE][ptr_idx(wptr_q[RD_RTN_SLICE])] = RD_RTN_DATA;
      wptr_d[RD_RTN_SLICE] = wptr_q[RD_RTN_SLICE] + PW'(1);
    end
    if (pop_c) begin
      rptr_d[cbank_c] = rptr_q[cbank_c] + PW'(1);
      pend_d[cbank_c][head_sel_c] = 1'b0;
    end
    if (issue_c) begin
      pend_d[SLICE][RD_REQ_SEL] = 1'b1;
    end
    for (int s = 0; s < 2; s++) begin
      if (issue_c && (SLICE == 1'(s)) && !(pop_c && (cbank_c == 1'(s)))) begin
        cnt_d[s] = cnt_q[s] + CW'(1);
      end else if (pop_c && (cbank_c == 1'(s)) && !(issue_c && (SLICE == 1'(s)))) begin
        cnt_d[s] = cnt_q[s] - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          sel_q[s][i]  <= '0;
          data_q[s][i] <= '0;
        end
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
        pend_q[s] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      data_q <= data_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_tawas_ld_wb_sched.sv
// Directed bench for tawas_ld_wb_sched with a per-slice writeback scoreboard.
module tb_tawas_ld_wb_sched;

  localparam int unsigned DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        SLICE = 1'b0;
  logic        RD_REQ = 1'b0;
  logic [2:0]  RD_REQ_SEL = 3'd0;
  logic        RD_REQ_RDY;
  logic        RD_RTN_VLD = 1'b0;
  logic        RD_RTN_SLICE = 1'b0;
  logic [2:0]  RD_RTN_SEL = 3'd0;
  logic [31:0] RD_RTN_DATA = 32'd0;
  logic        LS_LOAD_VLD;
  logic [2:0]  LS_LOAD_SEL;
  logic [31:0] LS_LOAD;
  logic [7:0]  PEND_0, PEND_1;
  logic        ERR;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
  } wb_t;

  wb_t exp0_q[$];
  wb_t exp1_q[$];
  int  checks = 0;
  int  errors = 0;

  tawas_ld_wb_sched #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .SLICE(SLICE),
    .RD_REQ(RD_REQ), .RD_REQ_SEL(RD_REQ_SEL), .RD_REQ_RDY(RD_REQ_RDY),
    .RD_RTN_VLD(RD_RTN_VLD), .RD_RTN_SLICE(RD_RTN_SLICE),
    .RD_RTN_SEL(RD_RTN_SEL), .RD_RTN_DATA(RD_RTN_DATA),
    .LS_LOAD_VLD(LS_LOAD_VLD), .LS_LOAD_SEL(LS_LOAD_SEL), .LS_LOAD(LS_LOAD),
    .PEND_0(PEND_0), .PEND_1(PEND_1), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: inputs held across the edge, then SLICE advances
  task automatic cyc(input bit req, input logic [2:0] rsel, input bit rv, input bit rs,
                     input logic [2:0] tsel, input logic [31:0] td, input bit push);
    wb_t e;
    RD_REQ = req; RD_REQ_SEL = rsel;
    RD_RTN_VLD = rv; RD_RTN_SLICE = rs; RD_RTN_SEL = tsel; RD_RTN_DATA = td;
    @(posedge CLK);
    #1;
    if (push) begin
      e.sel = tsel; e.data = td;
      if (rs) exp1_q.push_back(e);
      else    exp0_q.push_back(e);
    end
    RD_REQ = 1'b0; RD_RTN_VLD = 1'b0;
    SLICE = ~SLICE;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic issue(input logic [2:0] sel);
    cyc(1'b1, sel, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic rtn(input bit s, input logic [2:0] sel, input logic [31:0] d, input bit push);
    cyc(1'b0, 3'd0, 1'b1, s, sel, d, push);
  endtask

  task automatic wait_slice(input bit s);
    while (SLICE != s) idle();
  endtask

  task automatic probe_rdy(input string tag, input logic [2:0] sel, input bit exp);
    RD_REQ_SEL = sel;
    #1;
    check(tag, 32'(RD_REQ_RDY), 32'(exp));
    RD_REQ_SEL = 3'd0;
  endtask

  // Scoreboard: writeback must appear exactly when the committing bank has data
  initial begin
    logic c;
    int   qn;
    wb_t  e;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        c  = ~SLICE;
        qn = c ? exp1_q.size() : exp0_q.size();
        check("wb_vld", 32'(LS_LOAD_VLD), 32'(qn != 0));
        if (LS_LOAD_VLD && qn != 0) begin
          e = c ? exp1_q.pop_front() : exp0_q.pop_front();
          check("wb_sel", 32'(LS_LOAD_SEL), 32'(e.sel));
          check("wb_data", LS_LOAD, e.data);
        end else if (!LS_LOAD_VLD) begin
          check("idle_sel", 32'(LS_LOAD_SEL), 32'd0);
          check("idle_data", LS_LOAD, 32'd0);
        end
      end
    end
  end

  initial begin
    #1 RST_N = 1'b0;
    #2;
    check("rst_vld", 32'(LS_LOAD_VLD), 32'd0);
    check("rst_sel", 32'(LS_LOAD_SEL), 32'd0);
    check("rst_data", LS_LOAD, 32'd0);
    check("rst_pend0", 32'(PEND_0), 32'd0);
    check("rst_pend1", 32'(PEND_1), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    #1;

    // Basic issue, return, writeback in a SLICE=1 cycle
    wait_slice(1'b0);
    issue(3'd3);
    check("basic_pend0", 32'(PEND_0), 32'h08);
    check("basic_pend1", 32'(PEND_1), 32'h00);
    rtn(1'b0, 3'd3, 32'hDEADBEEF, 1'b1);
    check("basic_pend_hold", 32'(PEND_0), 32'h08);
    check("basic_no_wb_bank1", 32'(LS_LOAD_VLD), 32'd0);
    idle();
    check("basic_wb_vld", 32'(LS_LOAD_VLD), 32'd1);
    check("basic_wb_sel", 32'(LS_LOAD_SEL), 32'd3);
    check("basic_wb_data", LS_LOAD, 32'hDEADBEEF);
    idle();
    check("basic_pend_clr", 32'(PEND_0), 32'h00);
    probe_rdy("basic_rdy_again", 3'd3, 1'b1);

    // Backpressure on slice 1
    wait_slice(1'b1);
    issue(3'd1);
    idle();
    issue(3'd2);
    wait_slice(1'b1);
    probe_rdy("bp_cnt_full", 3'd4, 1'b0);
    probe_rdy("bp_pend_and_full", 3'd1, 1'b0);
    issue(3'd4);
    check("bp_pend1", 32'(PEND_1), 32'h06);
    probe_rdy("bp_slice0_ok", 3'd5, 1'b1);
    issue(3'd5);
    check("bp_pend0", 32'(PEND_0), 32'h20);

    // Interleaved returns on consecutive edges
    rtn(1'b1, 3'd2, 32'hA5A50001, 1'b1);
    check("il_wb1_vld", 32'(LS_LOAD_VLD), 32'd1);
    check("il_wb1_sel", 32'(LS_LOAD_SEL), 32'd2);
    rtn(1'b0, 3'd5, 32'hB4B40002, 1'b1);
    check("il_pend1", 32'(PEND_1), 32'h02);
    check("il_wb0_sel", 32'(LS_LOAD_SEL), 32'd5);
    idle();
    check("il_pend0", 32'(PEND_0), 32'h00);
    idle();
    probe_rdy("il_pend_block", 3'd1, 1'b0);
    probe_rdy("il_free_reg", 3'd2, 1'b1);

    // Enqueue and pop on the same FIFO, not full
    wait_slice(1'b0);
    issue(3'd3);
    idle();
    issue(3'd4);
    rtn(1'b0, 3'd3, 32'hC0C00003, 1'b1);
    idle();
    rtn(1'b0, 3'd4, 32'hD0D00004, 1'b1);
    check("sim_pend0", 32'(PEND_0), 32'h10);
    idle();
    check("sim_wb_sel", 32'(LS_LOAD_SEL), 32'd4);
    check("sim_wb_data", LS_LOAD, 32'hD0D00004);
    idle();
    check("sim_pend0_clr", 32'(PEND_0), 32'h00);
    check("sim_no_err", 32'(ERR), 32'd0);

    // Return to a non-pending register
    rtn(1'b1, 3'd7, 32'hEEEE0007, 1'b0);
    check("err_set", 32'(ERR), 32'd1);
    check("err_pend1", 32'(PEND_1), 32'h02);
    idle();
    idle();
    check("err_sticky", 32'(ERR), 32'd1);

    // Return into a full FIFO on a pop edge is dropped
    wait_slice(1'b0);
    issue(3'd3);
    idle();
    issue(3'd4);
    rtn(1'b0, 3'd3, 32'hF1F10003, 1'b1);
    rtn(1'b0, 3'd4, 32'hF2F20004, 1'b1);
    check("full_head_vld", 32'(LS_LOAD_VLD), 32'd1);
    rtn(1'b0, 3'd3, 32'h66660003, 1'b0);
    check("full_pend0", 32'(PEND_0), 32'h10);
    idle();
    idle();
    check("full_pend0_clr", 32'(PEND_0), 32'h00);
    idle();
    idle();

    // Reset with two entries buffered, then a stale return
    wait_slice(1'b0);
    issue(3'd3);
    idle();
    issue(3'd4);
    rtn(1'b0, 3'd3, 32'h11110003, 1'b1);
    rtn(1'b0, 3'd4, 32'h22220004, 1'b1);
    check("prerst_vld", 32'(LS_LOAD_VLD), 32'd1);
    RST_N = 1'b0;
    #1;
    exp0_q.delete();
    exp1_q.delete();
    check("mrst_vld", 32'(LS_LOAD_VLD), 32'd0);
    check("mrst_sel", 32'(LS_LOAD_SEL), 32'd0);
    check("mrst_data", LS_LOAD, 32'd0);
    check("mrst_pend0", 32'(PEND_0), 32'd0);
    check("mrst_err", 32'(ERR), 32'd0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    #1;
    rtn(1'b0, 3'd3, 32'h11110003, 1'b0);
    check("stale_err", 32'(ERR), 32'd1);
    check("stale_pend0", 32'(PEND_0), 32'd0);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
